// File: rtl/predictor_func_mac_loop.sv
// MPC predictor row MAC loop body: acc = bias + sum coef[k]*x[k].
// Four-stage II=1 pipeline fed by 1-cycle-latency BRAM reads.
module predictor_func_mac_loop #(
   parameter int N    = 8,
   parameter int DW   = 32,
   parameter int FRAC = 16,
   parameter int AW   = 3
) (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   input  logic          ap_start,
   output logic          ap_ready,
   output logic          ap_done,
   input  logic          ap_continue,
   input  logic          ap_loop_init,
   output logic          ap_loop_exit_ready,
   output logic          ap_loop_exit_done,
   input  logic [DW-1:0] bias,
   output logic [AW-1:0] coef_address0,
   output logic          coef_ce0,
   input  logic [DW-1:0] coef_q0,
   output logic [AW-1:0] x_address0,
   output logic          x_ce0,
   input  logic [DW-1:0] x_q0,
   output logic [DW-1:0] acc_out,
   output logic          acc_out_ap_vld
);

   localparam logic [AW-1:0] KLAST = AW'(N - 1);

   logic [AW-1:0] r_k;
   logic [AW-1:0] w_ki;
   logic          w_first0;
   logic          w_last0;
   logic          r_v1, r_f1, r_l1;
   logic          r_v2, r_f2, r_l2;
   logic          r_done;
   logic [DW-1:0] r_bias;
   logic [DW-1:0] r_p;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_acc_out;
   logic [DW-1:0] w_p;
   logic [DW-1:0] w_sum;
   logic signed [2*DW-1:0] w_prod;
   logic signed [2*DW-1:0] w_shift;
   logic          w_unused;

   // S0: issue
   assign w_ki     = ap_loop_init ? '0 : r_k;
   assign w_first0 = (w_ki == '0);
   assign w_last0  = (w_ki == KLAST);

   assign coef_address0      = w_ki;
   assign x_address0         = w_ki;
   assign coef_ce0           = ap_start;
   assign x_ce0              = ap_start;
   assign ap_ready           = ap_start;
   assign ap_loop_exit_ready = ap_start & w_last0;

   // Floor shift keeps the sign, so tiny negatives become -1 LSB
   assign w_prod  = $signed(coef_q0) * $signed(x_q0);
   assign w_shift = w_prod >>> FRAC;
   assign w_p     = w_shift[DW-1:0];
   assign w_sum   = (r_f2 ? r_bias : r_acc) + r_p;

   assign ap_done           = r_done;
   assign ap_loop_exit_done = r_done;
   assign acc_out_ap_vld    = r_done;
   assign acc_out           = r_acc_out;

   assign w_unused = ^{ap_continue, w_shift[2*DW-1:DW]};

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_k    <= '0;
         r_bias <= '0;
      end else if (ap_start) begin
         r_k <= w_last0 ? '0 : w_ki + AW'(1);
         if (w_first0) r_bias <= bias;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v1 <= 1'b0;
         r_f1 <= 1'b0;
         r_l1 <= 1'b0;
         r_v2 <= 1'b0;
         r_f2 <= 1'b0;
         r_l2 <= 1'b0;
         r_p  <= '0;
      end else begin
         r_v1 <= ap_start;
         r_f1 <= ap_start & w_first0;
         r_l1 <= ap_start & w_last0;
         r_v2 <= r_v1;
         r_f2 <= r_f1;
         r_l2 <= r_l1;
         r_p  <= w_p;
      end
   end

   // S3: accumulate; only a last iteration publishes a result
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_acc     <= '0;
         r_acc_out <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= r_v2 & r_l2;
         if (r_v2) begin
            r_acc <= w_sum;
            if (r_l2) r_acc_out <= w_sum;
         end
      end
   end

endmodule

// File: tb/tb_predictor_func_mac_loop.sv
// Directed bench for predictor_func_mac_loop with N=4.
// Behavioural BRAMs and a done-pulse monitor feed per-test checks.
module tb_predictor_func_mac_loop;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 3;
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          ap_start;
   logic          ap_ready;
   logic          ap_done;
   logic          ap_continue;
   logic          ap_loop_init;
   logic          ap_loop_exit_ready;
   logic          ap_loop_exit_done;
   logic [DW-1:0] bias;
   logic [AW-1:0] coef_address0;
   logic          coef_ce0;
   logic [DW-1:0] coef_q0;
   logic [AW-1:0] x_address0;
   logic          x_ce0;
   logic [DW-1:0] x_q0;
   logic [DW-1:0] acc_out;
   logic          acc_out_ap_vld;

   logic [31:0] cmem [0:7];
   logic [31:0] xmem [0:7];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cyc[$];
   logic [31:0] done_val[$];

   predictor_func_mac_loop #(.N(N), .DW(DW), .FRAC(16), .AW(AW)) dut (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .ap_start(ap_start),
      .ap_ready(ap_ready),
      .ap_done(ap_done),
      .ap_continue(ap_continue),
      .ap_loop_init(ap_loop_init),
      .ap_loop_exit_ready(ap_loop_exit_ready),
      .ap_loop_exit_done(ap_loop_exit_done),
      .bias(bias),
      .coef_address0(coef_address0),
      .coef_ce0(coef_ce0),
      .coef_q0(coef_q0),
      .x_address0(x_address0),
      .x_ce0(x_ce0),
      .x_q0(x_q0),
      .acc_out(acc_out),
      .acc_out_ap_vld(acc_out_ap_vld)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      cyc <= cyc + 1;
      if (coef_ce0) coef_q0 <= cmem[coef_address0];
      if (x_ce0) x_q0 <= xmem[x_address0];
   end

   always @(negedge ap_clk) begin
      if (ap_done) begin
         done_cyc.push_back(cyc);
         done_val.push_back(acc_out);
      end
   end

   task automatic step(input logic s, input logic init, input logic [31:0] b);
      @(negedge ap_clk);
      ap_start = s;
      ap_loop_init = init;
      bias = b;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, JUNK);
   endtask

   // bias is only valid on the first issue; later cycles drive junk
   task automatic issue_run(input int gap, input logic [31:0] b,
                            output int last);
      last = 0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, i == 0, (i == 0) ? b : JUNK);
         last = cyc;
         if (i < N - 1)
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, JUNK);
      end
   endtask

   task automatic load_ramp;
      for (int i = 0; i < 8; i++) begin
         cmem[i] = 32'h0001_0000;
         xmem[i] = (i + 1) << 16;
      end
   endtask

   task automatic clear_mon;
      done_cyc.delete();
      done_val.delete();
   endtask

   task automatic test_reset;
      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      ap_loop_init = 1'b0;
      ap_continue = 1'b1;
      bias = '0;
      repeat (3) @(negedge ap_clk);
      #1;
      vectors++;
      if ({ap_done, acc_out_ap_vld, ap_loop_exit_done, coef_ce0, x_ce0,
           ap_ready, ap_loop_exit_ready} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 0",
                  {ap_done, acc_out_ap_vld, ap_loop_exit_done, coef_ce0,
                   x_ce0, ap_ready, ap_loop_exit_ready});
      end
      vectors++;
      if (acc_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_acc_out got %h want 00000000", acc_out);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic;
      int last;
      load_ramp();
      clear_mon();
      last = 0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, i == 0, (i == 0) ? 32'h0 : JUNK);
         last = cyc;
         vectors++;
         if (ap_loop_exit_ready !== (i == N - 1) || coef_address0 !== AW'(i)
             || x_address0 !== AW'(i) || !ap_ready || !coef_ce0) begin
            miscompares++;
            $display("FAIL basic_issue%0d got er=%b a=%0d/%0d rdy=%b want er=%b a=%0d",
                     i, ap_loop_exit_ready, coef_address0, x_address0,
                     ap_ready, i == N - 1, i);
         end
      end
      step(1'b0, 1'b0, JUNK);
      vectors++;
      if (coef_ce0 !== 1'b0 || x_ce0 !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_ce_idle got %b%b want 00", coef_ce0, x_ce0);
      end
      idle(6);
      vectors++;
      if (done_cyc.size() != 1) begin
         miscompares++;
         $display("FAIL basic_done_count got %0d want 1", done_cyc.size());
      end else begin
         vectors++;
         if (done_val[0] !== 32'h000A_0000 || done_cyc[0] != last + 3) begin
            miscompares++;
            $display("FAIL basic_result got %h@%0d want 000a0000@%0d",
                     done_val[0], done_cyc[0], last + 3);
         end
      end
      vectors++;
      if (acc_out !== 32'h000A_0000 || ap_done !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_hold got %h done=%b want 000a0000 done=0",
                  acc_out, ap_done);
      end
   endtask

   task automatic test_negative;
      int last;
      for (int i = 0; i < 8; i++) begin
         cmem[i] = 32'hFFFF_8000;
         xmem[i] = 32'h0002_0000;
      end
      clear_mon();
      issue_run(0, 32'h0005_0000, last);
      idle(6);
      vectors++;
      if (done_val.size() != 1 || done_val[0] !== 32'h0001_0000) begin
         miscompares++;
         $display("FAIL neg_half got %h (n=%0d) want 00010000",
                  (done_val.size() > 0) ? done_val[0] : 32'hx, done_val.size());
      end
      xmem[0] = 32'h0000_0001;
      for (int i = 1; i < 8; i++) xmem[i] = 32'h0;
      clear_mon();
      issue_run(0, 32'h0, last);
      idle(6);
      vectors++;
      if (done_val.size() != 1 || done_val[0] !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL neg_floor got %h (n=%0d) want ffffffff",
                  (done_val.size() > 0) ? done_val[0] : 32'hx, done_val.size());
      end
   endtask

   task automatic test_bubbles;
      int last;
      load_ramp();
      clear_mon();
      last = 0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, i == 0, (i == 0) ? 32'h0 : JUNK);
         last = cyc;
         if (i < N - 1) begin
            step(1'b0, 1'b0, JUNK);
            vectors++;
            if (coef_ce0 !== 1'b0 || x_ce0 !== 1'b0 || ap_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL bubble_ce%0d got %b%b%b want 000",
                        i, coef_ce0, x_ce0, ap_ready);
            end
         end
      end
      idle(6);
      vectors++;
      if (done_cyc.size() != 1 || done_val[0] !== 32'h000A_0000
          || done_cyc[0] != last + 3) begin
         miscompares++;
         $display("FAIL bubble_result got n=%0d %h@%0d want 000a0000@%0d",
                  done_cyc.size(), (done_val.size() > 0) ? done_val[0] : 32'hx,
                  (done_cyc.size() > 0) ? done_cyc[0] : -1, last + 3);
      end
   endtask

   task automatic test_back_to_back;
      int la, lb;
      load_ramp();
      clear_mon();
      issue_run(0, 32'h0, la);
      issue_run(0, 32'h0001_0000, lb);
      idle(6);
      vectors++;
      if (done_cyc.size() != 2) begin
         miscompares++;
         $display("FAIL b2b_count got %0d want 2", done_cyc.size());
      end else begin
         vectors++;
         if (done_val[0] !== 32'h000A_0000 || done_val[1] !== 32'h000B_0000) begin
            miscompares++;
            $display("FAIL b2b_values got %h,%h want 000a0000,000b0000",
                     done_val[0], done_val[1]);
         end
         vectors++;
         if (done_cyc[1] - done_cyc[0] != 4 || done_cyc[1] != lb + 3) begin
            miscompares++;
            $display("FAIL b2b_timing got %0d,%0d want %0d,%0d",
                     done_cyc[0], done_cyc[1], la + 3, lb + 3);
         end
      end
   endtask

   // p truncates to 0x00010000; the bias push wraps past signed max
   task automatic test_overflow;
      int last;
      for (int i = 0; i < 8; i++) begin
         cmem[i] = 32'h7FFF_0000;
         xmem[i] = 32'h7FFF_0000;
      end
      clear_mon();
      issue_run(0, 32'h7FFF_0000, last);
      idle(6);
      vectors++;
      if (done_val.size() != 1 || done_val[0] !== 32'h8003_0000) begin
         miscompares++;
         $display("FAIL overflow got %h (n=%0d) want 80030000",
                  (done_val.size() > 0) ? done_val[0] : 32'hx, done_val.size());
      end
   endtask

   task automatic test_reset_midrun;
      int last;
      load_ramp();
      clear_mon();
      step(1'b1, 1'b1, 32'h0);
      step(1'b1, 1'b0, JUNK);
      @(negedge ap_clk);
      ap_start = 1'b0;
      ap_loop_init = 1'b0;
      ap_rst_n = 1'b0;
      #1;
      vectors++;
      if (acc_out !== 32'h0 || ap_done !== 1'b0 || coef_ce0 !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_clear got acc=%h done=%b ce=%b want 0/0/0",
                  acc_out, ap_done, coef_ce0);
      end
      idle(3);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      idle(5);
      vectors++;
      if (done_cyc.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_nodone got %0d pulses want 0", done_cyc.size());
      end
      issue_run(0, 32'h0, last);
      idle(6);
      vectors++;
      if (done_val.size() != 1 || done_val[0] !== 32'h000A_0000) begin
         miscompares++;
         $display("FAIL midrst_fresh got %h (n=%0d) want 000a0000",
                  (done_val.size() > 0) ? done_val[0] : 32'hx, done_val.size());
      end
   endtask

   task automatic test_abort;
      int last;
      load_ramp();
      clear_mon();
      step(1'b1, 1'b1, 32'h0005_0000);
      step(1'b1, 1'b0, JUNK);
      last = 0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, i == 0, (i == 0) ? 32'h0 : JUNK);
         last = cyc;
         if (i == 0) begin
            vectors++;
            if (coef_address0 !== '0 || ap_loop_exit_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL abort_restart got a=%0d er=%b want 0/0",
                        coef_address0, ap_loop_exit_ready);
            end
         end
      end
      idle(6);
      vectors++;
      if (done_cyc.size() != 1 || done_val[0] !== 32'h000A_0000
          || done_cyc[0] != last + 3) begin
         miscompares++;
         $display("FAIL abort_result got n=%0d %h want 1 000a0000",
                  done_cyc.size(), (done_val.size() > 0) ? done_val[0] : 32'hx);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_bubbles();
      test_back_to_back();
      test_overflow();
      test_reset_midrun();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/predictor_func_mac_loop.md
Name: predictor_func_mac_loop

Overview:
- Pipelined loop body (II=1) for one row of the MPC predictor: computes acc = bias + sum over k=0..N-1 of coef[k]*x[k], in signed fixed point.
- Sits directly under the predictor's flow-control loop wrapper and handshakes with it:
  - ap_start, ap_loop_init and ap_continue come from the wrapper.
  - ap_ready, ap_done, ap_loop_exit_ready and ap_loop_exit_done go back to it.
- Reads coef/x from single-port BRAMs with 1-cycle read latency.

Parameters:
N, 8, loop trip count (>=1)
DW, 32, data/accumulator width (signed)
FRAC, 16, fractional bits of Q(DW-FRAC).FRAC operands
AW, 3, address width, >= clog2(N)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  issue one iteration this cycle
ap_ready  out  1  iteration accepted this cycle (= ap_start)
ap_done  out  1  one-cycle pulse, result valid
ap_continue  in  1  wrapper ties to 1; ignored
ap_loop_init  in  1  first-iteration qualifier from wrapper
ap_loop_exit_ready  out  1  last iteration (k==N-1) issued this cycle
ap_loop_exit_done  out  1  last iteration retired; equals ap_done
bias  in  DW  accumulator seed; sampled on first issue
coef_address0  out  AW  coef BRAM address
coef_ce0  out  1  coef BRAM enable
coef_q0  in  DW  coef read data, 1 cycle after ce0
x_address0  out  AW  state BRAM address
x_ce0  out  1  state BRAM enable
x_q0  in  DW  state read data, 1 cycle after ce0
acc_out  out  DW  result; holds until next completion
acc_out_ap_vld  out  1  equals ap_done

Behaviour:
- Reset (async assert, sync release): k=0, all stage valid/first/last flags=0, bias_r=0, acc=0, acc_out=0. All handshake outputs and ce0 are 0.
- Pipeline, 4 stages, no back-pressure; ap_start=0 inserts a bubble (valid=0 propagates).
- S0, issue:
  - Effective index ki = ap_loop_init ? 0 : k.
  - coef_address0 = x_address0 = ki; ce0 = ap_start; ap_ready = ap_start.
  - first0 = (ki==0); last0 = (ki==N-1).
  - ap_loop_exit_ready = ap_start & last0.
  - On issue: k <= last0 ? 0 : ki+1. If first0 & ap_start, bias_r <= bias.
- S1: valid/first/last registered; coef_q0 and x_q0 valid in this cycle.
- S2: p <= (signed coef_q0 * signed x_q0), full 2*DW product, arithmetic shift right FRAC, truncated to low DW bits.
- S3: acc <= (first2 ? bias_r : acc) + p, modulo 2^DW (wraps, no saturation).
  - If last2: acc_out <= the new acc value, and done_r <= 1; otherwise done_r <= 0.
- ap_done = ap_loop_exit_done = acc_out_ap_vld = done_r.
- Latency: last iteration issued at cycle T gives ap_done=1 and a valid acc_out at cycle T+3, for exactly one cycle.
- Back-to-back runs: a new first issue at T+1 is legal. The first flag reseeds acc, so there is no cross-run contamination.
- N=1: every issue is both first and last; acc_out = bias + p.
- ap_loop_init asserted with k!=0 (run aborted):
  - k restarts at 0.
  - In-flight iterations of the old run retire into acc, but no done is produced for them.
  - The new first overwrites acc.
- bias changing mid-run has no effect (only bias_r is used).
- Reset mid-run: everything is cleared immediately and no ap_done is issued for the interrupted run.

Test Plan:
- N=4, FRAC=16, coef all 0x00010000, x = 0x00010000, 0x00020000, 0x00030000, 0x00040000, bias=0, ap_start held 4 cycles from T0 -> ap_loop_exit_ready=1 at T0+3; ap_done pulse at T0+6; acc_out=0x000A0000.
- Negatives/rounding: coef=0xFFFF8000 (-0.5), x=0x00020000 (2.0) all k, bias=0x00050000 -> acc_out=0x00010000 (5-4=1.0); and x=0x00000001 gives p=0xFFFFFFFF (floor shift), not 0.
- Bubbles: same data as test 1, ap_start low on alternate cycles -> acc_out=0x000A0000; ap_done exactly 3 cycles after the last issue; ce0 low during gaps.
- Back-to-back runs: run A (result 0x000A0000) then run B starting the next cycle with bias=0x00010000 -> two ap_done pulses 4 cycles apart; values 0x000A0000 then 0x000B0000.
- Overflow: coef=0x7FFF0000, x=0x7FFF0000, N=4 -> acc_out equals the 32-bit wrapped sum; no saturation.
- Reset/abort:
  - ap_rst_n low after 2 issues -> all outputs 0 immediately; after release, a fresh run gives the correct result.
  - ap_loop_init pulse at k=2 -> only one ap_done, with the new run's value.
